// File: rtl/fp_pkg.sv
// fp_pkg: shared width and state encoding for the divider arbiter
package fp_pkg;
    localparam int W = 32;
    typedef enum logic [2:0] {IDLE, ACCEPT, SEND_A, SEND_B, WAIT_Z, RETURN} state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority encoder starting at ptr
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] g,
    output logic          any
);
    always_comb begin
        g = '0;
        // scan downwards so the requester closest to ptr wins
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) g = IW'((int'(ptr) + i) % N);
    end
    assign any = |req;
endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one strobe/ack divider between N requesters
module fp_div_arbiter #(
    parameter int N  = 4,
    parameter int W  = fp_pkg::W,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N-1:0]  req_stb,
    output logic [N-1:0]  req_ack,
    output logic [W-1:0]  res_z,
    output logic [N-1:0]  res_stb,
    input  logic [N-1:0]  res_ack,
    output logic [W-1:0]  div_a,
    output logic          div_a_stb,
    input  logic          div_a_ack,
    output logic [W-1:0]  div_b,
    output logic          div_b_stb,
    input  logic          div_b_ack,
    input  logic [W-1:0]  div_z,
    input  logic          div_z_stb,
    output logic          div_z_ack,
    output logic          busy,
    output logic [IW-1:0] grant,
    output logic [15:0]   jobs_done
);
    import fp_pkg::*;
    state_t        r_state, w_state;
    logic [IW-1:0] r_ptr, w_ptr, r_grant, w_grant, w_pick;
    logic [N-1:0]  r_req_ack, w_req_ack, r_res_stb, w_res_stb;
    logic [W-1:0]  r_res_z, w_res_z, r_div_a, w_div_a, r_div_b, w_div_b;
    logic          r_a_stb, w_a_stb, r_b_stb, w_b_stb, r_z_ack, w_z_ack, w_any;
    logic [15:0]   r_jobs, w_jobs;

    rr_picker #(.N(N), .IW(IW)) u_pick (
        .req(req_stb),
        .ptr(r_ptr),
        .g  (w_pick),
        .any(w_any)
    );

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_grant   = r_grant;
        w_req_ack = r_req_ack;
        w_res_stb = r_res_stb;
        w_res_z   = r_res_z;
        w_div_a   = r_div_a;
        w_div_b   = r_div_b;
        w_a_stb   = r_a_stb;
        w_b_stb   = r_b_stb;
        w_z_ack   = r_z_ack;
        w_jobs    = r_jobs;
        unique case (r_state)
            IDLE: if (w_any) begin
                w_grant   = w_pick;
                w_req_ack = N'(1) << w_pick;
                w_state   = ACCEPT;
            end
            ACCEPT: if (req_stb[r_grant] && r_req_ack[r_grant]) begin
                w_div_a   = req_a[int'(r_grant) * W +: W];
                w_div_b   = req_b[int'(r_grant) * W +: W];
                w_req_ack = '0;
                w_a_stb   = 1'b1;
                w_state   = SEND_A;
            end else if (!req_stb[r_grant]) begin
                // requester withdrew: release it without advancing ptr
                w_req_ack = '0;
                w_state   = IDLE;
            end
            SEND_A: if (div_a_ack) begin
                w_a_stb = 1'b0;
                w_b_stb = 1'b1;
                w_state = SEND_B;
            end
            SEND_B: if (div_b_ack) begin
                w_b_stb = 1'b0;
                w_z_ack = 1'b1;
                w_state = WAIT_Z;
            end
            WAIT_Z: if (div_z_stb) begin
                w_res_z   = div_z;
                w_z_ack   = 1'b0;
                w_res_stb = N'(1) << r_grant;
                w_state   = RETURN;
            end
            RETURN: if (res_ack[r_grant]) begin
                w_res_stb = '0;
                w_ptr     = IW'((int'(r_grant) + 1) % N);
                w_jobs    = r_jobs + 16'd1;
                w_state   = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_req_ack <= '0;
            r_res_stb <= '0;
            r_res_z   <= '0;
            r_div_a   <= '0;
            r_div_b   <= '0;
            r_a_stb   <= 1'b0;
            r_b_stb   <= 1'b0;
            r_z_ack   <= 1'b0;
            r_jobs    <= '0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_grant   <= w_grant;
            r_req_ack <= w_req_ack;
            r_res_stb <= w_res_stb;
            r_res_z   <= w_res_z;
            r_div_a   <= w_div_a;
            r_div_b   <= w_div_b;
            r_a_stb   <= w_a_stb;
            r_b_stb   <= w_b_stb;
            r_z_ack   <= w_z_ack;
            r_jobs    <= w_jobs;
        end
    end

    assign req_ack   = r_req_ack;
    assign res_stb   = r_res_stb;
    assign res_z     = r_res_z;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign div_a_stb = r_a_stb;
    assign div_b_stb = r_b_stb;
    assign div_z_ack = r_z_ack;
    assign busy      = r_state != IDLE;
    assign grant     = r_grant;
    assign jobs_done = r_jobs;
endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: random clients and divider stub checked against a scoreboard
module tb_fp_div_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    logic           clk = 1'b0, rst = 1'b1;
    logic [N*W-1:0] req_a = '0, req_b = '0;
    logic [N-1:0]   req_stb = '0, res_ack = '0, req_ack, res_stb;
    logic [W-1:0]   res_z, div_a, div_b, div_z = '0;
    logic           div_a_stb, div_b_stb, div_z_ack, busy;
    logic           div_a_ack = 1'b0, div_b_ack = 1'b0, div_z_stb = 1'b0;
    logic [1:0]     grant;
    logic [15:0]    jobs_done;

    fp_div_arbiter #(.N(N), .W(W), .IW(2)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb),
        .req_ack(req_ack), .res_z(res_z), .res_stb(res_stb), .res_ack(res_ack),
        .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
        .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
        .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack),
        .busy(busy), .grant(grant), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    int n_err = 0, n_chk = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] s2d(input logic [31:0] s);
        return {s[31], 11'(int'(s[30:23]) + 896), s[22:0], 29'b0};
    endfunction
    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        real r;
        logic [63:0] d;
        r = $bitstoreal(s2d(a)) / $bitstoreal(s2d(b));
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction
    function automatic logic [31:0] rand_op();
        return {1'($urandom_range(1, 0)), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    logic [63:0] pend[N][$];
    logic [31:0] expq[N][$];
    logic [31:0] last_z[N];
    int          acc_log[$];
    int          waited[N], hc[N];
    bit          hs[N];
    int          done_cnt = 0, maxd = 0, lat = 5, hold_min = 0, hold_max = 0;
    int          dst = 0, dcnt = 0;
    logic [N-1:0] acc = '0, rtx = '0;
    logic        xa = 1'b0, xb = 1'b0, xz = 1'b0;
    logic [31:0] ca = '0, cb = '0, rz = '0;

    always @(posedge clk) begin
        acc = rst ? '0 : req_stb & req_ack;
        rtx = rst ? '0 : res_stb & res_ack;
        xa  = !rst && div_a_stb && div_a_ack;
        xb  = !rst && div_b_stb && div_b_ack;
        xz  = !rst && div_z_stb && div_z_ack;
        if (xa) ca = div_a;
        if (xb) cb = div_b;
        rz = res_z;
    end

    // divider stub: random ack delays, fixed compute latency plus jitter
    initial forever begin
        @(negedge clk);
        if (rst) begin
            dst = 0; dcnt = $urandom_range(maxd, 0);
            div_a_ack = 1'b0; div_b_ack = 1'b0; div_z_stb = 1'b0;
        end else case (dst)
            0: if (xa) begin
                div_a_ack = 1'b0; dst = 1; dcnt = $urandom_range(maxd, 0);
            end else if (div_a_stb && !div_a_ack) begin
                if (dcnt == 0) div_a_ack = 1'b1; else dcnt--;
            end
            1: if (xb) begin
                div_b_ack = 1'b0; dst = 2; dcnt = lat + $urandom_range(maxd, 0);
            end else if (div_b_stb && !div_b_ack) begin
                if (dcnt == 0) div_b_ack = 1'b1; else dcnt--;
            end
            2: if (dcnt == 0) begin
                div_z = fdiv(ca, cb); div_z_stb = 1'b1; dst = 3;
            end else dcnt--;
            default: if (xz) begin
                div_z_stb = 1'b0; dst = 0; dcnt = $urandom_range(maxd, 0);
            end
        endcase
    end

    // client models and scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst) for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                check("fairness", waited[i] <= N - 1, 1);
                waited[i] = 0;
                acc_log.push_back(i);
                expq[i].push_back(fdiv(pend[i][0][63:32], pend[i][0][31:0]));
                void'(pend[i].pop_front());
                req_stb[i] = 1'b0;
                for (int j = 0; j < N; j++) if (j != i && req_stb[j]) waited[j]++;
            end else if (!req_stb[i] && pend[i].size() > 0) begin
                req_a[i*W +: W] = pend[i][0][63:32];
                req_b[i*W +: W] = pend[i][0][31:0];
                req_stb[i] = 1'b1;
                waited[i] = 0;
            end
            if (rtx[i]) begin
                check("res_expected", expq[i].size() > 0, 1);
                if (expq[i].size() > 0) check("res_z", rz, expq[i].pop_front());
                last_z[i] = rz; res_ack[i] = 1'b0; hs[i] = 1'b0; done_cnt++;
            end else if (res_stb[i] && !res_ack[i]) begin
                if (!hs[i]) begin hs[i] = 1'b1; hc[i] = $urandom_range(hold_max, hold_min); end
                if (hc[i] == 0) res_ack[i] = 1'b1; else hc[i]--;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("req_ack_onehot", req_ack == 0 || req_ack == (N'(1) << grant), 1);
        check("res_stb_onehot", res_stb == 0 || res_stb == (N'(1) << grant), 1);
        check("div_single_stb", int'(div_a_stb) + int'(div_b_stb) + int'(div_z_ack) <= 1, 1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            pend[i].delete(); expq[i].delete(); hs[i] = 1'b0; waited[i] = 0;
        end
        req_stb = '0; res_ack = '0; done_cnt = 0; acc_log.delete();
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_ack"}, req_ack, 0);
        check({tag, "_res_stb"}, res_stb, 0);
        check({tag, "_div_stbs"}, {div_a_stb, div_b_stb, div_z_ack}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_jobs"}, jobs_done, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_data"}, {res_z, div_a}, 0);
    endtask

    task automatic wait_jobs(input int target, input int budget);
        int c = 0;
        while (done_cnt < target && c < budget) begin @(negedge clk); c++; end
        check("jobs_wait", done_cnt >= target, 1);
    endtask

    task automatic push_job(input int i, input logic [31:0] a, input logic [31:0] b);
        pend[i].push_back({a, b});
    endtask

    initial begin
        int c, pushed;
        logic [31:0] z0;
        do_reset();
        reset_checks("rst0");
        rst = 1'b0;
        // single job: 6.0 / 2.0
        @(posedge clk); push_job(1, 32'h40C00000, 32'h40000000);
        wait_jobs(1, 200);
        check("t1_acc_n", acc_log.size(), 1);
        check("t1_acc_id", acc_log[0], 1);
        check("t1_z", last_z[1], 32'h40400000);
        check("t1_jobs", jobs_done, 1);
        check("t1_ptr", dut.r_ptr, 2);
        check("t1_grant", grant, 1);
        // all four at once from reset
        do_reset(); rst = 1'b0;
        @(posedge clk);
        for (int i = 0; i < N; i++) push_job(i, rand_op(), rand_op());
        wait_jobs(4, 400);
        check("t2_acc_n", acc_log.size(), 4);
        for (int k = 0; k < 4; k++) check("t2_order", acc_log[k], k);
        check("t2_jobs", jobs_done, 4);
        // rotation from ptr=0 and ptr=1
        check("t3_ptr0", dut.r_ptr, 0);
        acc_log.delete();
        @(posedge clk); push_job(0, rand_op(), rand_op()); push_job(3, rand_op(), rand_op());
        wait_jobs(6, 400);
        check("t3_a_first", acc_log[0], 0);
        check("t3_a_second", acc_log[1], 3);
        @(posedge clk); push_job(0, rand_op(), rand_op());
        wait_jobs(7, 200);
        check("t3_ptr1", dut.r_ptr, 1);
        acc_log.delete();
        @(posedge clk); push_job(0, rand_op(), rand_op()); push_job(3, rand_op(), rand_op());
        wait_jobs(9, 400);
        check("t3_b_first", acc_log[0], 3);
        check("t3_b_second", acc_log[1], 0);
        // result backpressure
        hold_min = 20; hold_max = 20;
        @(posedge clk); push_job(2, rand_op(), rand_op());
        c = 0;
        while (!res_stb[2] && c < 200) begin @(negedge clk); c++; end
        check("t4_return", res_stb[2], 1);
        push_job(0, rand_op(), rand_op());
        z0 = res_z;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("t4_stb_hold", res_stb, 4'b0100);
            check("t4_z_hold", res_z, z0);
            check("t4_busy", busy, 1);
            check("t4_no_ack", req_ack, 0);
        end
        hold_min = 0; hold_max = 0;
        wait_jobs(11, 400);
        check("t4_jobs", jobs_done, 11);
        // 200 random jobs with random divider and client delays
        do_reset(); rst = 1'b0;
        maxd = 7; hold_max = 3; pushed = 0;
        for (int k = 0; k < 20000 && pushed < 200; k++) begin
            @(posedge clk);
            if ($urandom_range(3, 0) == 0) begin
                push_job($urandom_range(N - 1, 0), rand_op(), rand_op());
                pushed++;
            end
        end
        wait_jobs(200, 40000);
        check("t5_jobs", jobs_done, 200);
        check("t5_accepts", acc_log.size(), 200);
        // reset while waiting on the divider result
        maxd = 0; hold_max = 0;
        @(posedge clk); push_job(1, rand_op(), rand_op());
        c = 0;
        while (!div_z_ack && c < 200) begin @(negedge clk); c++; end
        check("t6_wait_z", div_z_ack, 1);
        do_reset();
        reset_checks("t6");
        rst = 1'b0;
        @(posedge clk); push_job(2, 32'h41100000, 32'h40400000);
        wait_jobs(1, 200);
        check("t6_z", last_z[2], 32'h40400000);
        check("t6_jobs", jobs_done, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
